// File: rtl/psr_flag_unit_if.sv
// rtl/psr_flag_unit_if.sv - execute/decode-side signal bundle for the flag register and branch stage
interface psr_flag_unit_if #(
  parameter int DEPTH = 4
);
  logic [4:0]                   status_in;
  logic                         status_we;
  logic                         stall;
  logic                         save;
  logic                         restore;
  logic [3:0]                   cond;
  logic                         cond_valid;
  logic [4:0]                   flags;
  logic                         taken;
  logic                         taken_valid;
  logic [$clog2(DEPTH+1)-1:0]   depth;
  logic                         ovf_err;
  logic                         unf_err;

  modport master (
    output status_in, status_we, stall, save, restore, cond, cond_valid,
    input  flags, taken, taken_valid, depth, ovf_err, unf_err
  );

  modport slave (
    input  status_in, status_we, stall, save, restore, cond, cond_valid,
    output flags, taken, taken_valid, depth, ovf_err, unf_err
  );
endinterface

// File: rtl/psr_flag_unit.sv
// rtl/psr_flag_unit.sv - committed flags, interrupt save/restore LIFO and registered branch decision
module psr_flag_unit #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  psr_flag_unit_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    flags_q, flags_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          taken_q, taken_d;
  logic          taken_valid_q, taken_valid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [4:0]    stack_q [DEPTH];

  logic          push_req, pop_req, full, empty, do_push, do_pop, cond_hit;
  logic [4:0]    top;

  // save and restore together cancel each other out entirely
  assign push_req = bus.save & ~bus.restore;
  assign pop_req  = bus.restore & ~bus.save;
  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign do_push  = push_req & ~full & ~bus.stall;
  assign do_pop   = pop_req & ~empty & ~bus.stall;
  assign top      = stack_q[AW'(depth_q - DW'(1))];

  // branch condition sees the flags being committed this cycle
  always_comb begin
    cond_hit = 1'b0;
    case (bus.cond)
      4'd0:    cond_hit = 1'b1;
      4'd1:    cond_hit = 1'b0;
      4'd2:    cond_hit = flags_d[2];
      4'd3:    cond_hit = ~flags_d[2];
      4'd4:    cond_hit = flags_d[4];
      4'd5:    cond_hit = ~flags_d[4];
      4'd6:    cond_hit = flags_d[0];
      4'd7:    cond_hit = ~flags_d[0];
      4'd8:    cond_hit = flags_d[1];
      4'd9:    cond_hit = ~flags_d[1];
      4'd10:   cond_hit = flags_d[3];
      4'd11:   cond_hit = flags_d[4] & ~flags_d[2];
      4'd12:   cond_hit = ~flags_d[4] | flags_d[2];
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    flags_d       = flags_q;
    depth_d       = depth_q;
    taken_d       = taken_q;
    taken_valid_d = taken_valid_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    if (!bus.stall) begin
      if (do_pop) begin
        flags_d = top;
      end else if (bus.status_we) begin
        flags_d = bus.status_in;
      end
      if (do_push) depth_d = depth_q + DW'(1);
      if (do_pop)  depth_d = depth_q - DW'(1);
      if (push_req && full)  ovf_d = 1'b1;
      if (pop_req && empty)  unf_d = 1'b1;
      taken_valid_d = bus.cond_valid;
      taken_d       = bus.cond_valid & cond_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q       <= '0;
      depth_q       <= '0;
      taken_q       <= 1'b0;
      taken_valid_q <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      depth_q       <= depth_d;
      taken_q       <= taken_d;
      taken_valid_q <= taken_valid_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  // entries above depth are don't-care, so the storage needs no reset
  always_ff @(posedge clk) begin
    if (do_push) stack_q[AW'(depth_q)] <= flags_q;
  end

  assign bus.flags       = flags_q;
  assign bus.depth       = depth_q;
  assign bus.taken       = taken_q;
  assign bus.taken_valid = taken_valid_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_psr_flag_unit.sv
// tb/tb_psr_flag_unit.sv - bench for psr_flag_unit with a queue-based reference model
module tb_psr_flag_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psr_flag_unit_if #(.DEPTH(DEPTH)) bus ();
  psr_flag_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [4:0] m_flags = '0;
  logic [4:0] m_stack[$];
  logic       m_taken = 1'b0;
  logic       m_tv    = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_unf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic z, cy;
    z  = f[2];
    cy = f[4];
    if (c == 0) return 1'b1;
    if (c == 2 || c == 3) return (c == 2) ? z : !z;
    if (c == 4 || c == 5) return (c == 4) ? cy : !cy;
    if (c == 6 || c == 7) return (c == 6) ? f[0] : !f[0];
    if (c == 8 || c == 9) return (c == 8) ? f[1] : !f[1];
    if (c == 10) return f[3];
    if (c == 11) return cy && !z;
    if (c == 12) return !cy || z;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_taken = 1'b0;
    m_tv    = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Applies one cycle of inputs, advances the model, returns #1 after the checking edge
  task automatic cyc(input logic we, input logic [4:0] s, input logic sv, input logic rs,
                     input logic [3:0] c, input logic cv, input logic st);
    logic [4:0] fn;
    bit popped;
    bus.status_we  = we;
    bus.status_in  = s;
    bus.save       = sv;
    bus.restore    = rs;
    bus.cond       = c;
    bus.cond_valid = cv;
    bus.stall      = st;
    if (!rst && !st) begin
      fn = m_flags;
      popped = 0;
      if (rs && !sv) begin
        if (m_stack.size() > 0) begin
          fn = m_stack.pop_back();
          popped = 1;
        end else begin
          m_unf = 1'b1;
        end
      end
      if (!popped && we) fn = s;
      if (sv && !rs) begin
        if (m_stack.size() == DEPTH) m_ovf = 1'b1;
        else m_stack.push_back(m_flags);
      end
      m_tv    = cv;
      m_taken = cv ? cond_true(c, fn) : 1'b0;
      m_flags = fn;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 5'd0, 0, 0, 4'd0, 0, 0);
  endtask

  always @(negedge clk) begin
    chk("flags", 32'(bus.flags), 32'(m_flags));
    chk("depth", 32'(bus.depth), 32'(m_stack.size()));
    chk("taken", 32'(bus.taken), 32'(m_taken));
    chk("taken_valid", 32'(bus.taken_valid), 32'(m_tv));
    chk("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
    chk("unf_err", 32'(bus.unf_err), 32'(m_unf));
  end

  logic [4:0] vals [6] = '{5'b00000, 5'b10110, 5'b01001, 5'b11010, 5'b00101, 5'b11111};

  initial begin
    bus.status_in = '0; bus.status_we = 0; bus.stall = 0; bus.save = 0;
    bus.restore = 0; bus.cond = '0; bus.cond_valid = 0;

    // reset held with random inputs
    for (int i = 0; i < 4; i++)
      cyc(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b0;
    idle();
    chk("rst_flags", 32'(bus.flags), 0);
    chk("rst_depth", 32'(bus.depth), 0);

    // flag write with bypassed carry branch
    cyc(1, 5'b10110, 0, 0, 4'd4, 1, 0);
    chk("wr_flags", 32'(bus.flags), 32'(5'b10110));
    chk("wr_taken", 32'(bus.taken), 1);
    chk("wr_tv", 32'(bus.taken_valid), 1);
    idle();
    chk("wr_tv_pulse", 32'(bus.taken_valid), 0);

    // save, overwrite, restore beats write
    cyc(1, 5'b00100, 0, 0, 4'd0, 0, 0);
    cyc(0, 5'd0, 1, 0, 4'd0, 0, 0);
    chk("sv_depth", 32'(bus.depth), 1);
    cyc(1, 5'b01010, 0, 0, 4'd0, 0, 0);
    cyc(1, 5'b11111, 0, 1, 4'd2, 1, 0);
    chk("rs_flags", 32'(bus.flags), 32'(5'b00100));
    chk("rs_depth", 32'(bus.depth), 0);
    chk("rs_taken_bypass", 32'(bus.taken), 1);

    // save+restore together: write only, no stack op
    cyc(1, 5'b00011, 1, 1, 4'd0, 0, 0);
    chk("both_flags", 32'(bus.flags), 32'(5'b00011));
    chk("both_depth", 32'(bus.depth), 0);

    // five saves into a four-deep stack, distinct flags each time
    for (int i = 0; i < 5; i++) cyc(1, 5'(i + 8), 1, 0, 4'd0, 0, 0);
    chk("ovf_depth", 32'(bus.depth), 4);
    chk("ovf_err", 32'(bus.ovf_err), 1);
    chk("ovf_flags", 32'(bus.flags), 32'(5'd12));
    cyc(0, 5'd0, 0, 1, 4'd0, 0, 0);
    chk("lifo0", 32'(bus.flags), 32'(5'd10));
    cyc(0, 5'd0, 0, 1, 4'd0, 0, 0);
    chk("lifo1", 32'(bus.flags), 32'(5'd9));
    cyc(0, 5'd0, 0, 1, 4'd0, 0, 0);
    chk("lifo2", 32'(bus.flags), 32'(5'd8));
    cyc(0, 5'd0, 0, 1, 4'd0, 0, 0);
    chk("lifo3", 32'(bus.flags), 32'(5'b00011));
    chk("lifo_depth", 32'(bus.depth), 0);

    // underflow lets the write through
    cyc(1, 5'b01000, 0, 1, 4'd0, 0, 0);
    chk("unf_flags", 32'(bus.flags), 32'(5'b01000));
    chk("unf_err", 32'(bus.unf_err), 1);
    chk("unf_depth", 32'(bus.depth), 0);

    // stall freezes everything, then reserved condition
    cyc(1, 5'b11111, 1, 0, 4'd0, 1, 1);
    chk("stall_flags", 32'(bus.flags), 32'(5'b01000));
    chk("stall_depth", 32'(bus.depth), 0);
    chk("stall_tv", 32'(bus.taken_valid), 0);
    cyc(0, 5'd0, 0, 0, 4'd14, 1, 0);
    chk("rsv_taken", 32'(bus.taken), 0);
    chk("rsv_tv", 32'(bus.taken_valid), 1);

    // every condition code against several flag patterns, bypassed
    for (int c = 0; c < 16; c++)
      for (int k = 0; k < 6; k++) cyc(1, vals[k], 0, 0, 4'(c), 1, 0);
    cyc(1, 5'b10000, 0, 0, 4'd11, 1, 0);
    chk("c11_lit", 32'(bus.taken), 1);
    cyc(1, 5'b10100, 0, 0, 4'd12, 1, 0);
    chk("c12_lit", 32'(bus.taken), 1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));

    // asynchronous reset mid-operation
    cyc(1, 5'b11111, 1, 0, 4'd0, 1, 0);
    rst = 1'b1;
    model_reset();
    #2;
    chk("arst_flags", 32'(bus.flags), 0);
    chk("arst_depth", 32'(bus.depth), 0);
    chk("arst_tv", 32'(bus.taken_valid), 0);
    chk("arst_errs", 32'({bus.ovf_err, bus.unf_err}), 0);
    idle();
    rst = 1'b0;
    cyc(1, 5'b00110, 0, 0, 4'd8, 1, 0);
    chk("post_rst_flags", 32'(bus.flags), 32'(5'b00110));
    chk("post_rst_taken", 32'(bus.taken), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/psr_flag_unit.md
# psr_flag_unit

Architectural flag register and branch-condition stage that sits directly downstream of `psr`. It commits the 5-bit program status produced in execute and saves/restores it across interrupts on a small LIFO stack. It also evaluates branch condition codes against the committed flags, delivering a registered taken/not-taken decision to fetch.

## Interface
- `DEPTH`, 4: save/restore stack entries (≥1)
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `status_in` in 5: `program_status` from `psr`; bit map: [0] odd parity, [1] even value, [2] zero, [3] nonzero, [4] carry
- `status_we` in 1: execute-stage instruction writes flags this cycle
- `stall` in 1: pipeline stall; freezes all state and outputs
- `save` in 1: interrupt entry; push committed flags
- `restore` in 1: interrupt return; pop into flags
- `cond` in 4: branch condition code from decode
- `cond_valid` in 1: `cond` is a live branch this cycle
- `flags` out 5: committed flags, registered
- `taken` out 1: branch decision, registered
- `taken_valid` out 1: `taken` corresponds to a `cond_valid` of the previous cycle
- `depth` out $clog2(DEPTH+1): stack occupancy
- `ovf_err` out 1: sticky; push while full
- `unf_err` out 1: sticky; pop while empty

## Operation
- **Reset values** (async): `flags`=0, stack empty, `depth`=0, `taken`=0, `taken_valid`=0, `ovf_err`=0, `unf_err`=0.
- **Stall.** If `stall`=1, every register holds. All other inputs are ignored that cycle, and errors are not set.
- **Next-flags selection**, highest priority first:
  - `restore` only, stack non-empty: flags ← top entry.
  - `status_we`: flags ← `status_in`.
  - Otherwise: hold.
- **Stack operations**, each exclusive of the other:
  - `save` only: push the current (pre-update) `flags`. `status_we` in the same cycle still updates `flags`.
  - `restore` only: pop.
  - `save` and `restore` together: no stack operation and no restore. `status_we` still applies.
- **Full stack.** `save` is ignored and `ovf_err` ← 1.
- **Empty stack.** `restore` is ignored, `unf_err` ← 1, and `status_we` in that cycle applies normally.
- **Restore beats write.** When `restore` succeeds, a simultaneous `status_we` is dropped.
- **Condition evaluation** uses `fn` = the next-flags value (bypass). A branch in the same cycle as a flag write sees the new flags.
- **Condition codes:**
  - 0: always
  - 1: never
  - 2: Z (`fn[2]`)
  - 3: !Z
  - 4: C (`fn[4]`)
  - 5: !C
  - 6: odd parity (`fn[0]`)
  - 7: !`fn[0]`
  - 8: even value (`fn[1]`)
  - 9: !`fn[1]`
  - 10: nonzero (`fn[3]`)
  - 11: C & !Z
  - 12: !C | Z
  - 13–15: reserved, taken=0
- **Branch outputs.** `taken_valid` ← `cond_valid`. `taken` ← evaluated condition when `cond_valid`=1, else 0.
- **Error flags** clear only on reset.

## Timing
- `flags` updates one cycle after `status_we`, `restore`, or a successful pop.
- `taken` and `taken_valid` have 1-cycle latency from `cond`/`cond_valid`. `taken_valid` is a single-cycle pulse per valid branch.
- `depth` updates at the same edge as the push or pop.
- Stack is LIFO and never wraps. Entries above `depth` are don't-care.
- No combinational path from any input to any output.
- Reset asserted mid-operation clears all state immediately. The first valid operation is on the first edge after deassertion.

## Test plan
- **Reset.** Hold `rst` with random inputs, then release → all outputs 0 and `depth`=0.
- **Flag write plus bypass branch.** `status_in`=5'b10110, `status_we`=1, `cond`=4, `cond_valid`=1 → next cycle `flags`=5'b10110, `taken`=1, `taken_valid`=1. One cycle later `taken_valid`=0.
- **Save/restore.** Flags 5'b00100, `save`; write 5'b01010; `restore` with `status_we`=1 and `status_in`=5'b11111 → `flags`=5'b00100, `depth`=0.
- **Overflow.** 5 `save`s with `DEPTH`=4 → `depth`=4, `ovf_err`=1. The next 4 `restore`s return entries in LIFO order.
- **Underflow.** `restore` on an empty stack with `status_we`=1 and `status_in`=5'b01000 → `flags`=5'b01000, `unf_err`=1, `depth`=0.
- **Stall and reserved code.** `stall`=1 with `status_we`, `save`, and `cond_valid` → no change. Then `cond`=14, `cond_valid`=1 → `taken`=0, `taken_valid`=1.
